// File: rtl/grey_seg_pkg.sv
// grey_seg_pkg
//   Shared types and constants for the grey-code 7-segment display stage:
//   scan FSM states, error cause codes, segment patterns (active-high,
//   [0]=a .. [6]=g), the ten legal 5-bit grey codes, and small helpers for
//   BCD-to-segment mapping and per-digit step legality.
package grey_seg_pkg;

    typedef enum logic [1:0] {
        SHOW_ONES = 2'd0,
        BLANK_A   = 2'd1,
        SHOW_TENS = 2'd2,
        BLANK_B   = 2'd3
    } scan_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CODE = 2'b01,
        ERR_STEP = 2'b10
    } err_code_e;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [4:0] GREY_0 = 5'b00000;
    localparam logic [4:0] GREY_1 = 5'b00001;
    localparam logic [4:0] GREY_2 = 5'b00011;
    localparam logic [4:0] GREY_3 = 5'b00010;
    localparam logic [4:0] GREY_4 = 5'b00110;
    localparam logic [4:0] GREY_5 = 5'b00100;
    localparam logic [4:0] GREY_6 = 5'b01100;
    localparam logic [4:0] GREY_7 = 5'b01000;
    localparam logic [4:0] GREY_8 = 5'b11000;
    localparam logic [4:0] GREY_9 = 5'b10000;

    // Any nibble outside 0..9 renders as 'E'.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    // A digit may hold or advance by one, wrapping 9 -> 0.
    function automatic logic step_ok(input logic [3:0] prev, input logic [3:0] cur);
        logic [3:0] nxt;
        nxt = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        return (cur == prev) || (cur == nxt);
    endfunction

endpackage

// File: rtl/grey_dec.sv
// grey_dec
//   Combinational 5-bit grey code to BCD decoder for one display digit.
//   Ports:
//     i_code   in  5  grey code from the counter
//     o_valid  out 1  high when i_code is one of the ten legal codes
//     o_bcd    out 4  decoded digit 0..9, 4'hF when invalid
module grey_dec
    import grey_seg_pkg::*;
(
    input  logic [4:0] i_code,
    output logic       o_valid,
    output logic [3:0] o_bcd
);

    always_comb begin
        o_valid = 1'b1;
        o_bcd   = 4'hF;
        case (i_code)
            GREY_0:  o_bcd = 4'd0;
            GREY_1:  o_bcd = 4'd1;
            GREY_2:  o_bcd = 4'd2;
            GREY_3:  o_bcd = 4'd3;
            GREY_4:  o_bcd = 4'd4;
            GREY_5:  o_bcd = 4'd5;
            GREY_6:  o_bcd = 4'd6;
            GREY_7:  o_bcd = 4'd7;
            GREY_8:  o_bcd = 4'd8;
            GREY_9:  o_bcd = 4'd9;
            default: begin
                o_valid = 1'b0;
                o_bcd   = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/grey_seg_mux.sv
// grey_seg_mux
//   Display stage for a two-digit grey-code counter. Registers the ones/tens
//   codes, decodes them to BCD, drives a time-multiplexed 2-digit 7-segment
//   display with blanking between digit slots, and flags illegal codes or
//   illegal count steps with a sticky error.
//   Parameters:
//     REFRESH_DIV   cycles each digit is lit per slot (>=2)
//     BLANK_CYCLES  dark cycles between slots (>=1)
//   Ports:
//     i_clk       in  1  clock, rising edge
//     i_rst       in  1  asynchronous active-high reset
//     i_ones      in  5  ones digit grey code
//     i_tens      in  5  tens digit grey code
//     o_seg       out 7  segments, active-high, [0]=a .. [6]=g
//     o_dig       out 2  digit enable: 01 ones, 10 tens, 00 blank
//     o_bcd       out 8  {tens_bcd, ones_bcd}, 4'hF for an invalid digit
//     o_err       out 1  sticky error
//     o_err_code  out 2  first error cause: 00 none, 01 code, 10 step
//   Build option:
//     GREY_SEG_LZB_EN  blank the tens digit when it is a valid zero
module grey_seg_mux
    import grey_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_ones,
    input  logic [4:0] i_tens,
    output logic [6:0] o_seg,
    output logic [1:0] o_dig,
    output logic [7:0] o_bcd,
    output logic       o_err,
    output logic [1:0] o_err_code
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYCLES - 1);

    // Capture and checking state
    logic [4:0]  ones_q, tens_q;
    logic        cap_vld_q;
    logic        primed_q;
    logic [3:0]  prev_ones_q, prev_tens_q;
    logic        prev_ones_vld_q, prev_tens_vld_q;
    logic [7:0]  bcd_q;
    logic        err_q;
    err_code_e   err_code_q;

    // Scan state
    scan_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  dig_q, dig_d;

    logic        ones_vld, tens_vld;
    logic [3:0]  ones_bcd, tens_bcd;
    logic        code_bad, step_bad;
    logic [CNT_W-1:0] slot_last;

    grey_dec u_dec_ones (
        .i_code  (ones_q),
        .o_valid (ones_vld),
        .o_bcd   (ones_bcd)
    );

    grey_dec u_dec_tens (
        .i_code  (tens_q),
        .o_valid (tens_vld),
        .o_bcd   (tens_bcd)
    );

    // cap_vld_q keeps the reset contents of the capture registers out of
    // the checker, so the first real sample after reset is the one that
    // primes it rather than being step-checked against 00000.
    always_comb begin
        code_bad = 1'b0;
        step_bad = 1'b0;
        if (cap_vld_q) begin
            code_bad = !ones_vld || !tens_vld;
            if (primed_q) begin
                step_bad = (ones_vld && prev_ones_vld_q && !step_ok(prev_ones_q, ones_bcd)) ||
                           (tens_vld && prev_tens_vld_q && !step_ok(prev_tens_q, tens_bcd));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ones_q          <= '0;
            tens_q          <= '0;
            cap_vld_q       <= 1'b0;
            primed_q        <= 1'b0;
            prev_ones_q     <= '0;
            prev_tens_q     <= '0;
            prev_ones_vld_q <= 1'b0;
            prev_tens_vld_q <= 1'b0;
            bcd_q           <= '0;
            err_q           <= 1'b0;
            err_code_q      <= ERR_NONE;
        end else begin
            ones_q    <= i_ones;
            tens_q    <= i_tens;
            cap_vld_q <= 1'b1;
            bcd_q     <= {tens_bcd, ones_bcd};
            if (cap_vld_q) begin
                primed_q <= 1'b1;
                // Invalid codes never become the reference for the next step.
                if (ones_vld) begin
                    prev_ones_q     <= ones_bcd;
                    prev_ones_vld_q <= 1'b1;
                end
                if (tens_vld) begin
                    prev_tens_q     <= tens_bcd;
                    prev_tens_vld_q <= 1'b1;
                end
            end
            if (!err_q && (code_bad || step_bad)) begin
                err_q      <= 1'b1;
                err_code_q <= code_bad ? ERR_CODE : ERR_STEP;
            end
        end
    end

    // Outputs are registered from the current state, so o_dig trails the
    // state by one cycle and each slot is visible for exactly N cycles.
    always_comb begin
        seg_d     = SEG_BLANK;
        dig_d     = 2'b00;
        slot_last = BLK_LAST;
        case (state_q)
            SHOW_ONES: begin
                dig_d     = 2'b01;
                seg_d     = ones_vld ? bcd_to_seg(ones_bcd) : SEG_E;
                slot_last = REF_LAST;
            end
            SHOW_TENS: begin
                dig_d     = 2'b10;
                seg_d     = tens_vld ? bcd_to_seg(tens_bcd) : SEG_E;
`ifdef GREY_SEG_LZB_EN
                if (tens_vld && (tens_bcd == 4'd0)) begin
                    seg_d = SEG_BLANK;
                end
`else
`endif
                slot_last = REF_LAST;
            end
            default: begin
                dig_d     = 2'b00;
                seg_d     = SEG_BLANK;
                slot_last = BLK_LAST;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= SHOW_ONES;
            cnt_q   <= '0;
            seg_q   <= '0;
            dig_q   <= '0;
        end else begin
            seg_q <= seg_d;
            dig_q <= dig_d;
            if (cnt_q == slot_last) begin
                cnt_q <= '0;
                case (state_q)
                    SHOW_ONES: state_q <= BLANK_A;
                    BLANK_A:   state_q <= SHOW_TENS;
                    SHOW_TENS: state_q <= BLANK_B;
                    default:   state_q <= SHOW_ONES;
                endcase
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_seg      = seg_q;
    assign o_dig      = dig_q;
    assign o_bcd      = bcd_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_grey_seg_mux.sv
// tb_grey_seg_mux
//   Directed testbench for grey_seg_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_grey_seg_mux;

    logic       clk;
    logic       rst;
    logic [4:0] ones;
    logic [4:0] tens;
    logic [6:0] seg;
    logic [1:0] dig;
    logic [7:0] bcd;
    logic       err;
    logic [1:0] err_code;

    int n_tests;
    int n_fail;

    logic [4:0] gt [10];

    grey_seg_mux #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ones     (ones),
        .i_tens     (tens),
        .o_seg      (seg),
        .o_dig      (dig),
        .o_bcd      (bcd),
        .o_err      (err),
        .o_err_code (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reset with the given codes presented; releases on a falling edge.
    task automatic do_reset(input logic [4:0] o, input logic [4:0] t);
        @(negedge clk);
        rst  = 1'b1;
        ones = o;
        tens = t;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Bounded wait for a digit enable value; a timeout shows up as a failed check.
    task automatic wait_dig(input string tag, input logic [1:0] want);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (dig == want) break;
        end
        check(tag, dig, want);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        logic [1:0] exp_dig;
        logic [6:0] exp_seg;
        logic [7:0] exp_bcd;
        int v;

        n_tests = 0;
        n_fail  = 0;
        gt = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
               5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};

        // ---- 1: reset values and scan sequence with 12 held ----
        rst  = 1'b0;
        ones = 5'b00011;
        tens = 5'b00001;
        #2 rst = 1'b1;
        #1;
        check("rst_seg", seg, 7'h00);
        check("rst_dig", dig, 2'b00);
        check("rst_bcd", bcd, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if ((j % 20) < 8)       begin exp_dig = 2'b01; exp_seg = 7'h5B; end
            else if ((j % 20) < 10) begin exp_dig = 2'b00; exp_seg = 7'h00; end
            else if ((j % 20) < 18) begin exp_dig = 2'b10; exp_seg = 7'h06; end
            else                    begin exp_dig = 2'b00; exp_seg = 7'h00; end
            check("t1_dig", dig, exp_dig);
            // the first lit cycle still shows the reset capture (00000 -> 3F)
            if (j == 0) check("t1_seg0", seg, 7'h3F);
            else begin
                check("t1_seg", seg, exp_seg);
                check("t1_bcd", bcd, 8'h12);
            end
        end
        check("t1_err", err, 1'b0);

        // ---- 2: full count 00..99..00, one step per cycle ----
        do_reset(gt[0], gt[0]);
        ones = gt[0];
        tens = gt[0];
        for (int i = 1; i <= 102; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                v = (i - 2) % 100;
                exp_bcd = {4'(v / 10), 4'(v % 10)};
                check("t2_bcd", bcd, exp_bcd);
                check("t2_err", err, 1'b0);
            end
            if (i <= 100) begin
                v = i % 100;
                ones = gt[v % 10];
                tens = gt[v / 10];
            end
        end

        // ---- 3: illegal code on ones ----
        do_reset(5'b00011, 5'b00001);
        wait_cycles(4);
        check("t3_err_pre", err, 1'b0);
        ones = 5'b00101;
        wait_cycles(2);
        check("t3_bcd", bcd, 8'h1F);
        check("t3_err", err, 1'b1);
        check("t3_code", err_code, 2'b01);
        wait_dig("t3_wait_ones", 2'b01);
        check("t3_seg", seg, 7'h79);
        ones = 5'b00011;
        wait_cycles(2);
        check("t3_bcd_back", bcd, 8'h12);
        check("t3_err_stay", err, 1'b1);
        check("t3_code_stay", err_code, 2'b01);

        // ---- 4: illegal step 2 -> 4, later illegal code ignored ----
        do_reset(5'b00011, 5'b00000);
        wait_cycles(4);
        check("t4_err_pre", err, 1'b0);
        ones = 5'b00110;
        wait_cycles(2);
        check("t4_bcd", bcd, 8'h04);
        check("t4_err", err, 1'b1);
        check("t4_code", err_code, 2'b10);
        ones = 5'b00101;
        wait_cycles(2);
        check("t4_code_frozen", err_code, 2'b10);
        check("t4_err_stay", err, 1'b1);

        // ---- 6: async reset mid tens slot with o_err set ----
        wait_dig("t6_wait_tens", 2'b10);
        ones = 5'b00110;
        tens = 5'b00011;
        #2 rst = 1'b1;
        #1;
        check("t6_seg", seg, 7'h00);
        check("t6_dig", dig, 2'b00);
        check("t6_bcd", bcd, 8'h00);
        check("t6_err", err, 1'b0);
        check("t6_code", err_code, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_dig_first", dig, 2'b01);
        wait_cycles(3);
        check("t6_bcd_after", bcd, 8'h24);
        check("t6_seg_after", seg, 7'h66);
        check("t6_err_after", err, 1'b0);

        // ---- 5: tens zero, leading-zero blanking option ----
        do_reset(5'b00110, 5'b00000);
        wait_dig("t5_wait_tens", 2'b10);
`ifdef GREY_SEG_LZB_EN
        check("t5_tens_seg", seg, 7'h00);
`else
        check("t5_tens_seg", seg, 7'h3F);
`endif
        wait_dig("t5_wait_ones", 2'b01);
        check("t5_ones_seg", seg, 7'h66);
        check("t5_bcd", bcd, 8'h04);
        check("t5_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
